regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Sequencer and arbiter for the 8-register byte file's single transfer port. Shares the file between four requesters, each asking for one register-to-register move (src index -> dst index). For each granted move it drives the 3-bit read select of the 8:1 byte read mux, captures the selected byte, then drives the 3-bit select and enable of the 3-to-8 write decoder. Requesters are served in round-robin order with a req/ack handshake.

## Interface
- RD_WAIT, 0, extra settle cycles in READ before capture; legal range 0-7
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  4  per-requester request; held high until its ack
- src  in  12  packed read indices, requester i on src[3i+2:3i]
- dst  in  12  packed write indices, requester i on dst[3i+2:3i]
- rdata  in  8  byte from the read mux output
- rsel  out  3  read-mux select (S2..S0)
- ren  out  1  read phase active
- wsel  out  3  write-decoder select (S2..S0)
- wen  out  1  write-decoder enable (En)
- wdata  out  8  byte to write, valid while wen=1
- gnt  out  4  one-hot owner of the current transfer
- ack  out  4  one-cycle completion pulse to the owner
- busy  out  1  state != IDLE

## Operation
- States: IDLE, READ, WRITE. A 3-bit counter runs inside READ.
- IDLE:
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - Latch owner, src_l = src[owner], dst_l = dst[owner]; clear cnt; go to READ.
  - If no req bit is set, stay in IDLE.
- READ:
  - rsel = src_l, ren = 1, gnt = onehot(owner).
  - If cnt == RD_WAIT: tmp <= rdata and go to WRITE. Otherwise cnt <= cnt+1.
- WRITE:
  - wsel = dst_l, wen = 1, wdata = tmp, gnt held, ack[owner] = 1.
  - ptr <= owner+1 (mod 4, 3 wraps to 0).
  - Always return to IDLE.
- All outputs are decoded from registered state and latched fields only. There is no combinational path from req/src/dst to any output.
- When not in READ, rsel and ren are 0. When not in WRITE, wsel, wen, wdata and ack are 0. gnt is 0 in IDLE.
- src/dst are sampled only in IDLE at grant. Later changes are ignored.
- Once granted, a transfer always completes. If the owner drops req early, ack is still issued and the write still occurs.
- src_l == dst_l is legal; the register is rewritten with its own value.
- Non-owner requests wait. A requester whose req stays high after ack is treated as a new request at the next IDLE.

## Timing
- Reset (rstn low, asynchronous):
  - state=IDLE, ptr=0, owner=0, cnt=0, tmp=0.
  - All outputs are 0 immediately.
- Release of reset takes effect on the first rising edge with rstn high.
- Req sampled in IDLE at edge E:
  - READ occupies cycles E+1 .. E+1+RD_WAIT.
  - rdata is captured at the edge closing the last READ cycle.
  - WRITE occupies 1 cycle with wen=1 and ack pulsed.
  - IDLE occupies the next cycle.
- Ack arrives RD_WAIT+2 cycles after the grant edge.
- Per-transfer occupancy is RD_WAIT+3 cycles, including one IDLE cycle between transfers.
- Round-robin: with all four requesting continuously, the grant order is 0,1,2,3,0,... and no requester waits more than 3 transfers.
- Reset asserted mid-transfer aborts it: no wen, no ack. The aborted requester must re-request; its req still high is re-arbitrated from ptr=0.

## Test plan
- Reset, RD_WAIT=0, req=0001, src0=2, dst0=5, rdata=0xA5 during READ -> READ with rsel=2, ren=1; next cycle wen=1, wsel=5, wdata=0xA5, ack=0001; gnt=0001 over both cycles.
- All four requesting simultaneously and continuously, re-raising after ack -> grants 0,1,2,3,0 in order; a new grant every 3 cycles; exactly one ack bit per WRITE.
- RD_WAIT=3, rdata changing each cycle during READ -> the byte captured is the value in the 4th READ cycle; ack 5 cycles after the grant edge.
- Owner 1 drops req and changes src/dst the cycle after grant -> wsel/wdata use the latched values; ack[1] is still pulsed.
- rstn pulsed low during WRITE -> wen, ack and gnt go to 0 asynchronously; after release, ptr=0 and a pending req=1010 is granted to requester 1 first.
- src==dst==7 with rdata=0x3C -> rsel=7, then wsel=7, wdata=0x3C, ack pulsed.

Source files
------------

// File: rtl/regbus_arbiter.sv
// Round-robin sequencer for the 8-register byte file's single transfer port.
// Each granted move is a READ phase (mux select + settle + capture) followed by one WRITE cycle.

module regbus_arb_slot #(
  parameter int IDX = 0
) (
  input  logic [1:0] owner,
  input  logic       own_phase,
  input  logic       wr_phase,
  output logic       gnt,
  output logic       ack
);
  logic mine;
  assign mine = (owner == 2'(IDX));
  assign gnt  = mine & own_phase;
  assign ack  = mine & wr_phase;
endmodule

module regbus_arbiter #(
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [11:0] src,
  input  logic [11:0] dst,
  input  logic [7:0]  rdata,
  output logic [2:0]  rsel,
  output logic        ren,
  output logic [2:0]  wsel,
  output logic        wen,
  output logic [7:0]  wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        busy
);
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                    state, state_nx;
  logic [1:0]                ptr, owner, pick, idx;
  logic [2:0]                cnt, src_l, dst_l;
  logic [7:0]                tmp;
  logic                      found, any_req, rd_done;
  logic [NUM_REQ-1:0][2:0]   src_v, dst_v;

  assign src_v   = src;
  assign dst_v   = dst;
  assign any_req = |req;
  assign rd_done = (cnt == 3'(RD_WAIT));

  // First set request scanning upward from ptr, wrapping mod 4.
  always_comb begin
    pick  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = READ;
      READ:    if (rd_done) state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      tmp   <= '0;
      src_l <= '0;
      dst_l <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= pick;
          src_l <= src_v[pick];
          dst_l <= dst_v[pick];
          cnt   <= '0;
        end
        READ: begin
          if (rd_done) tmp <= rdata;
          else         cnt <= cnt + 3'd1;
        end
        WRITE: ptr <= owner + 2'd1;
        default: ;
      endcase
    end
  end

  // Outputs come only from registered state and latched fields.
  assign rsel  = (state == READ)  ? src_l : 3'd0;
  assign ren   = (state == READ);
  assign wsel  = (state == WRITE) ? dst_l : 3'd0;
  assign wen   = (state == WRITE);
  assign wdata = (state == WRITE) ? tmp : 8'd0;
  assign busy  = (state != IDLE);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    regbus_arb_slot #(.IDX(i)) u_slot (
      .owner     (owner),
      .own_phase (state != IDLE),
      .wr_phase  (state == WRITE),
      .gnt       (gnt[i]),
      .ack       (ack[i])
    );
  end
endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: a RD_WAIT=0 and a RD_WAIT=3 instance share stimulus,
// directed vectors/sequences plus random traffic against a timeline model.
module tb_regbus_arbiter;
  logic        clk, rstn;
  logic [3:0]  req;
  logic [11:0] src, dst;
  logic [7:0]  rdata;

  logic [2:0] rsel0, wsel0, rsel3, wsel3;
  logic       ren0, wen0, busy0, ren3, wen3, busy3;
  logic [7:0] wdata0, wdata3;
  logic [3:0] gnt0, ack0, gnt3, ack3;
  logic [24:0] ob0, ob3;

  int checks = 0;
  int errors = 0;

  regbus_arbiter #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rstn(rstn), .req(req), .src(src), .dst(dst), .rdata(rdata),
    .rsel(rsel0), .ren(ren0), .wsel(wsel0), .wen(wen0), .wdata(wdata0),
    .gnt(gnt0), .ack(ack0), .busy(busy0));

  regbus_arbiter #(.RD_WAIT(3)) dut3 (
    .clk(clk), .rstn(rstn), .req(req), .src(src), .dst(dst), .rdata(rdata),
    .rsel(rsel3), .ren(ren3), .wsel(wsel3), .wen(wen3), .wdata(wdata3),
    .gnt(gnt3), .ack(ack3), .busy(busy3));

  assign ob0 = {rsel0, ren0, wsel0, wen0, wdata0, gnt0, ack0, busy0};
  assign ob3 = {rsel3, ren3, wsel3, wen3, wdata3, gnt3, ack3, busy3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic logic [24:0] pk(logic [2:0] rs, logic re, logic [2:0] ws, logic we,
                                     logic [7:0] wd, logic [3:0] g, logic [3:0] a, logic b);
    return {rs, re, ws, we, wd, g, a, b};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req = '0; src = '0; dst = '0; rdata = '0;
    #1;
    chk("reset_out0", ob0, 0);
    chk("reset_out3", ob3, 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Timeline model: a transfer granted in idle cycle g reads in g+1..g+1+RW,
  // writes in g+2+RW, and the next arbitration happens at g+3+RW.
  int          rw    [2] = '{0, 3};
  bit          m_act [2];
  int          m_g   [2];
  int          m_own [2];
  int          m_ptr [2];
  logic [2:0]  m_src [2], m_dst [2];
  logic [7:0]  m_tmp [2];

  function automatic logic [24:0] mexp(int k, int n);
    int rel;
    logic [3:0] oh;
    if (!m_act[k]) return '0;
    rel = n - m_g[k];
    oh  = 4'b0001 << m_own[k];
    if (rel >= 1 && rel <= 1 + rw[k]) return pk(m_src[k], 1'b1, 3'd0, 1'b0, 8'd0, oh, 4'd0, 1'b1);
    if (rel == 2 + rw[k])             return pk(3'd0, 1'b0, m_dst[k], 1'b1, m_tmp[k], oh, oh, 1'b1);
    return '0;
  endfunction

  task automatic model_step(int n);
    int rel, o;
    for (int k = 0; k < 2; k++) begin
      rel = n - m_g[k];
      if (m_act[k] && rel == 1 + rw[k]) m_tmp[k] = rdata;
      if ((!m_act[k] || rel >= rw[k] + 3) && req != 4'd0) begin
        o = m_ptr[k];
        while (!req[o]) o = (o + 1) % 4;
        m_act[k] = 1'b1;
        m_g[k]   = n;
        m_own[k] = o;
        m_src[k] = src[3*o +: 3];
        m_dst[k] = dst[3*o +: 3];
        m_ptr[k] = (o + 1) % 4;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [11:0] src;
    logic [11:0] dst;
    logic [7:0]  rdata;
    logic [24:0] exp;
  } vec_t;

  vec_t tv[7];

  initial begin
    int ngr, last, cyc;
    tv[0] = '{4'b0001, 12'h005 - 12'h003, 12'h005, 8'h00, 25'd0};
    tv[1] = '{4'b0001, 12'h002, 12'h005, 8'hA5, pk(3'd2, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b1)};
    tv[2] = '{4'b0000, 12'h002, 12'h005, 8'h00, pk(3'd0, 1'b0, 3'd5, 1'b1, 8'hA5, 4'b0001, 4'b0001, 1'b1)};
    tv[3] = '{4'b0100, 12'h1C0, 12'h1C0, 8'h00, 25'd0};
    tv[4] = '{4'b0100, 12'h1C0, 12'h1C0, 8'h3C, pk(3'd7, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b1)};
    tv[5] = '{4'b0000, 12'h000, 12'h000, 8'h00, pk(3'd0, 1'b0, 3'd7, 1'b1, 8'h3C, 4'b0100, 4'b0100, 1'b1)};
    tv[6] = '{4'b0000, 12'h000, 12'h000, 8'h00, 25'd0};

    rstn = 1'b0; req = '0; src = '0; dst = '0; rdata = '0;

    // Basic move 2->5 then a self-move 7->7 on the RD_WAIT=0 instance
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req = tv[i].req; src = tv[i].src; dst = tv[i].dst; rdata = tv[i].rdata;
      chk($sformatf("table[%0d]", i), ob0, tv[i].exp);
    end

    // RD_WAIT=3: capture in the 4th READ cycle, ack 5 cycles after the request cycle
    do_reset();
    @(negedge clk);
    req = 4'b0001; src = 12'h001; dst = 12'h004;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rdata = 8'h10 + 8'(k);
      if (k <= 4)      chk($sformatf("rw3_read%0d", k), ob3, pk(3'd1, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b1));
      else if (k == 5) chk("rw3_write", ob3, pk(3'd0, 1'b0, 3'd4, 1'b1, 8'h14, 4'b0001, 4'b0001, 1'b1));
      else             chk("rw3_idle", ob3, 0);
      if (k >= 5) req = 4'b0000;
    end

    // Owner 1 drops req and changes src/dst right after grant
    do_reset();
    @(negedge clk);
    req = 4'b0010; src = 12'h018; dst = 12'h030;
    @(negedge clk);
    chk("drop_read", ob0, pk(3'd3, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1));
    req = 4'b0000; src = 12'hFFF; dst = 12'h000; rdata = 8'h5A;
    @(negedge clk);
    chk("drop_write", ob0, pk(3'd0, 1'b0, 3'd6, 1'b1, 8'h5A, 4'b0010, 4'b0010, 1'b1));
    @(negedge clk);
    chk("drop_idle", ob0, 0);

    // All four requesting continuously
    do_reset();
    ngr = 0; last = -1;
    for (cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      req = 4'b1111; src = 12'($urandom); dst = 12'($urandom); rdata = 8'($urandom);
      if (ren0) begin
        chk($sformatf("rr_gnt%0d", ngr), gnt0, 4'b0001 << (ngr % 4));
        if (last >= 0) chk("rr_spacing", cyc - last, 3);
        last = cyc;
        ngr++;
      end
      if (wen0) chk("rr_ack_onehot", $countones(ack0), 1);
    end
    chk("rr_count", ngr, 5);

    // Reset during WRITE aborts; ptr returns to 0 so req=1010 goes to requester 1
    do_reset();
    @(negedge clk);
    req = 4'b0100; src = 12'h028 << 3; dst = 12'h028 << 3;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wen", wen0, 1);
    #2 rstn = 1'b0;
    #1 chk("mid_rst_out", ob0, 0);
    req = 4'b1010; src = 12'h028; dst = 12'h000;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", ob0, pk(3'd5, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1));

    // Random traffic on both instances against the model
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_g[k] = 0; m_own[k] = 0; m_ptr[k] = 0;
      m_src[k] = '0; m_dst[k] = '0; m_tmp[k] = '0;
    end
    model_step(0);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      chk("rand_rw0", ob0, mexp(0, n));
      chk("rand_rw3", ob3, mexp(1, n));
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 99) < 40);
        else if ($urandom_range(0, 99) < 8) req[i] = 1'b0;
      end
      src = 12'($urandom); dst = 12'($urandom); rdata = 8'($urandom);
      model_step(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
